// File: rtl/multififo_rd_sched.sv
// Read-side burst scheduler for the 1-write/8-read multififo.
// Optional counters: define MULTIFIFO_RD_SCHED_STATS_EN.
module multififo_rd_sched #(
  parameter int WIDTH   = 32,
  parameter int MAXRD   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   softreset,
  input  logic [15:0]            fifo_count,
  input  logic [WIDTH*MAXRD-1:0] fifo_dout,
  output logic [3:0]             fifo_reads,
  input  logic [3:0]             burst_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*MAXRD-1:0] out_data,
  output logic [3:0]             out_num,
  output logic                   out_flush,
`ifdef MULTIFIFO_RD_SCHED_STATS_EN
  input  logic                   stat_clr,
  output logic [31:0]            stat_bursts,
  output logic [31:0]            stat_flushes,
`endif
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  localparam logic [3:0] MAXL = 4'(MAXRD);

  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, tinc;
  logic [15:0] cnt_q;
  logic [3:0] len_q, len, n;
  logic [15:0] len16;
  logic slot_free, clr;
  logic out_valid_q, out_flush_q, flush_d;
  logic [3:0] out_num_q;
  logic [WIDTH*MAXRD-1:0] out_data_q, data_d;

  assign clr = !rst_n || softreset;
  assign len = (burst_len == 4'd0) ? 4'd1 :
               (burst_len > MAXL) ? MAXL : burst_len;
  assign len16 = {12'd0, len};
  assign slot_free = !out_valid_q || out_ready;
  assign tinc = (timer_q == TLIM) ? TLIM : timer_q + 1'b1;

  always_comb begin
    n = 4'd0;
    if (slot_free && fifo_count >= len16)
      n = len;
    else if (slot_free && state_q == FLUSH && fifo_count != 16'd0)
      n = (fifo_count < len16) ? fifo_count[3:0] : len;
  end

  assign fifo_reads = n;
  assign flush_d = (state_q == FLUSH) && (n < len);

  always_comb begin
    data_d = '0;
    for (int k = 0; k < MAXRD; k++)
      if (4'(k) < n)
        data_d[k*WIDTH +: WIDTH] = fifo_dout[k*WIDTH +: WIDTH];
  end

  // A count or length change restarts the partial-burst wait.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (fifo_count == 16'd0) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (fifo_count >= len16) begin
      state_d = ACCUM;
      timer_d = '0;
    end else if (state_q == FLUSH) begin
      state_d = (n != 4'd0) ? ACCUM : FLUSH;
      timer_d = (n != 4'd0) ? '0 : tinc;
    end else if (fifo_count != cnt_q || len != len_q) begin
      state_d = ACCUM;
      timer_d = '0;
    end else begin
      timer_d = tinc;
      state_d = (tinc == TLIM) ? FLUSH : ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_num_q   <= '0;
      out_flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= fifo_count;
      len_q   <= len;
      if (n != 4'd0) begin
        out_valid_q <= 1'b1;
        out_data_q  <= data_d;
        out_num_q   <= n;
        out_flush_q <= flush_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_num   = out_num_q;
  assign out_flush = out_flush_q;
  assign busy      = (state_q != IDLE) || out_valid_q;

`ifdef MULTIFIFO_RD_SCHED_STATS_EN
  logic [31:0] bursts_q, flushes_q;

  always_ff @(posedge clk) begin
    if (clr || stat_clr) begin
      bursts_q  <= '0;
      flushes_q <= '0;
    end else if (n != 4'd0) begin
      if (flush_d) flushes_q <= flushes_q + 32'd1;
      else         bursts_q  <= bursts_q + 32'd1;
    end
  end

  assign stat_bursts  = bursts_q;
  assign stat_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_multififo_rd_sched.sv
// Directed self-checking bench for multififo_rd_sched.
// Expected values are hand-derived for TIMEOUT=16.
module tb_multififo_rd_sched;

  logic         clk = 1'b0;
  logic         rst_n, softreset, out_ready;
  logic [15:0]  fifo_count;
  logic [255:0] fifo_dout, out_data;
  logic [3:0]   fifo_reads, burst_len, out_num;
  logic         out_valid, out_flush, busy;
`ifdef MULTIFIFO_RD_SCHED_STATS_EN
  logic         stat_clr;
  logic [31:0]  stat_bursts, stat_flushes;
`endif

  int total = 0;
  int bad = 0;
  logic [255:0] pb, pc;

  always #5 clk = ~clk;

  multififo_rd_sched #(.WIDTH(32), .MAXRD(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .softreset(softreset),
    .fifo_count(fifo_count), .fifo_dout(fifo_dout),
    .fifo_reads(fifo_reads), .burst_len(burst_len),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_num(out_num),
    .out_flush(out_flush),
`ifdef MULTIFIFO_RD_SCHED_STATS_EN
    .stat_clr(stat_clr), .stat_bursts(stat_bursts),
    .stat_flushes(stat_flushes),
`endif
    .busy(busy)
  );

  function automatic logic [255:0] pat(input logic [31:0] b);
    pat = '0;
    for (int k = 0; k < 8; k++) pat[k*32 +: 32] = b + 32'(k);
  endfunction

  function automatic logic [255:0] msk(input logic [255:0] d,
                                       input int n);
    msk = '0;
    for (int k = 0; k < n; k++) msk[k*32 +: 32] = d[k*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; softreset = 1'b0; out_ready = 1'b1;
    fifo_count = 16'd0; burst_len = 4'd4;
    fifo_dout = pat(32'hA000_0000);
`ifdef MULTIFIFO_RD_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_num", 256'(out_num), 256'(0));
    chk("rst_flush", 256'(out_flush), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_data", out_data, '0);
    chk("rst_reads", 256'(fifo_reads), 256'(0));

    // full burst of 4
    fifo_count = 16'd4; #1;
    chk("t1_reads", 256'(fifo_reads), 256'(4));
    tick();
    fifo_count = 16'd0; #1;
    chk("t1_valid", 256'(out_valid), 256'(1));
    chk("t1_num", 256'(out_num), 256'(4));
    chk("t1_flush", 256'(out_flush), 256'(0));
    chk("t1_data", out_data, msk(pat(32'hA000_0000), 4));
    tick();
    chk("t1_drop", 256'(out_valid), 256'(0));

    // timeout flush of 3 entries with L=8
    burst_len = 4'd8; fifo_count = 16'd3;
    fifo_dout = pat(32'hB100_0000);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("t2_wait", 256'(fifo_reads), 256'(0));
      tick();
    end
    chk("t2_busy", 256'(busy), 256'(1));
    chk("t2_reads", 256'(fifo_reads), 256'(3));
    tick();
    fifo_count = 16'd0; #1;
    chk("t2_num", 256'(out_num), 256'(3));
    chk("t2_flush", 256'(out_flush), 256'(1));
    chk("t2_data", out_data, msk(pat(32'hB100_0000), 3));
    tick();

    // backpressure hold, then reload with no gap
    pb = pat(32'hC200_0000); pc = pat(32'hD300_0000);
    out_ready = 1'b0; fifo_count = 16'd8; fifo_dout = pb; #1;
    chk("t3_reads0", 256'(fifo_reads), 256'(8));
    tick();
    fifo_dout = pc; #1;
    chk("t3_hold_reads", 256'(fifo_reads), 256'(0));
    tick();
    chk("t3_hold_data", out_data, pb);
    chk("t3_hold_num", 256'(out_num), 256'(8));
    out_ready = 1'b1; #1;
    chk("t3_reads1", 256'(fifo_reads), 256'(8));
    tick();
    chk("t3_valid", 256'(out_valid), 256'(1));
    chk("t3_data", out_data, pc);

    // continuous pairs
    fifo_count = 16'd16; burst_len = 4'd2;
    for (int i = 0; i < 4; i++) begin
      fifo_dout = pat(32'hE000_0000 + 32'(i * 16)); #1;
      chk("t4_reads", 256'(fifo_reads), 256'(2));
      tick();
      chk("t4_valid", 256'(out_valid), 256'(1));
      chk("t4_num", 256'(out_num), 256'(2));
      chk("t4_data", out_data,
          msk(pat(32'hE000_0000 + 32'(i * 16)), 2));
    end
    fifo_count = 16'd0; tick(); tick();
    chk("t4_idle", 256'(busy), 256'(0));

    // partial wait, then length drops to the count
    fifo_count = 16'd2; burst_len = 4'd4;
    fifo_dout = pat(32'hF000_0000);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t5_wait", 256'(fifo_reads), 256'(0));
      tick();
    end
    burst_len = 4'd2; #1;
    chk("t5_reads", 256'(fifo_reads), 256'(2));
    tick();
    fifo_count = 16'd0; #1;
    chk("t5_num", 256'(out_num), 256'(2));
    chk("t5_flush", 256'(out_flush), 256'(0));
    tick();

    // length clamping
    fifo_count = 16'd1; burst_len = 4'd0; #1;
    chk("len0_reads", 256'(fifo_reads), 256'(1));
    tick();
    chk("len0_num", 256'(out_num), 256'(1));
    fifo_count = 16'd9; burst_len = 4'd15; #1;
    chk("len15_reads", 256'(fifo_reads), 256'(8));
    tick();
    chk("len15_num", 256'(out_num), 256'(8));
    fifo_count = 16'd0; tick();

    // flush under backpressure, then softreset
    burst_len = 4'd8; fifo_count = 16'd3; out_ready = 1'b0;
    fifo_dout = pat(32'h1100_0000);
    for (int i = 0; i < 16; i++) tick();
    chk("t6_reads", 256'(fifo_reads), 256'(3));
    tick();
    chk("t6_flush", 256'(out_flush), 256'(1));
    for (int i = 0; i < 20; i++) tick();
    chk("t6_bp_reads", 256'(fifo_reads), 256'(0));
    chk("t6_held_num", 256'(out_num), 256'(3));
    chk("t6_held_valid", 256'(out_valid), 256'(1));
`ifdef MULTIFIFO_RD_SCHED_STATS_EN
    chk("t6_stat_fl", 256'(stat_flushes), 256'(2));
`endif
    softreset = 1'b1; fifo_count = 16'd0;
    tick();
    softreset = 1'b0; #1;
    chk("sr_valid", 256'(out_valid), 256'(0));
    chk("sr_num", 256'(out_num), 256'(0));
    chk("sr_flush", 256'(out_flush), 256'(0));
    chk("sr_busy", 256'(busy), 256'(0));
    chk("sr_data", out_data, '0);
`ifdef MULTIFIFO_RD_SCHED_STATS_EN
    chk("sr_stat_b", 256'(stat_bursts), 256'(0));
    chk("sr_stat_f", 256'(stat_flushes), 256'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
